// File: rtl/wbm_mtest.sv
// wbm_mtest: Wishbone classic memory tester (pattern write pass, read/compare pass).
// Define WBM_MTEST_CONT_EN to keep re-running with seed+1 while start stays high.
module wbm_mtest #(
  parameter logic [15:0] ADDR_START = 16'h0000,
  parameter logic [15:0] ADDR_END   = 16'h3FFE,
  parameter int          TIMEOUT    = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        start,
  input  logic [15:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        tmo,
  output logic [7:0]  err_cnt,
  output logic [15:0] err_adr,
  output logic [15:0] err_dat,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WGAP, S_RD, S_RGAP, S_FIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [15:0]   r_seed;
  logic [15:0]   r_adr;
  logic [15:0]   r_err_adr;
  logic [15:0]   r_err_dat;
  logic [7:0]    r_err_cnt;
  logic [TW-1:0] r_wait;
  logic          r_tmo;
  logic          r_pass;
  logic          w_cyc;
  logic          w_we;
  logic          w_tmo_hit;
  logic          w_at_end;
  logic          w_wait_max;
  logic          w_miss;
  logic [15:0]   w_pat;

  assign w_pat      = r_adr ^ r_seed;
  assign w_at_end   = (r_adr == ADDR_END);
  assign w_wait_max = (r_wait == TW'(TIMEOUT - 1));
  assign w_miss     = (wb_dat_i != w_pat);

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);
  assign pass     = r_pass;
  assign tmo      = r_tmo;
  assign err_cnt  = r_err_cnt;
  assign err_adr  = r_err_adr;
  assign err_dat  = r_err_dat;
  assign wb_cyc_o = w_cyc;
  assign wb_stb_o = w_cyc;
  assign wb_we_o  = w_we;
  assign wb_sel_o = {2{w_cyc}};
  assign wb_adr_o = w_cyc ? r_adr : 16'h0000;
  assign wb_dat_o = w_we ? w_pat : 16'h0000;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cyc      = 1'b0;
    w_we       = 1'b0;
    w_tmo_hit  = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_nx = S_WR;
      S_WR, S_RD: begin
        w_cyc = 1'b1;
        w_we  = (r_state == S_WR);
        if (wb_ack_i) begin
          w_state_nx = (r_state == S_WR) ? S_WGAP : S_RGAP;
        end else if (w_wait_max) begin
          w_tmo_hit  = 1'b1;
          w_state_nx = S_FIN;
        end
      end
      S_WGAP: w_state_nx = w_at_end ? S_RD : S_WR;
      S_RGAP: w_state_nx = w_at_end ? S_FIN : S_RD;
      S_FIN: begin
`ifdef WBM_MTEST_CONT_EN
        w_state_nx = (start && !r_tmo) ? S_WR : S_IDLE;
`else
        w_state_nx = S_IDLE;
`endif
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_seed    <= '0;
      r_adr     <= '0;
      r_err_adr <= '0;
      r_err_dat <= '0;
      r_err_cnt <= '0;
      r_wait    <= '0;
      r_tmo     <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_wait <= (w_cyc && !wb_ack_i) ? r_wait + 1'b1 : '0;
      if (w_tmo_hit) r_tmo <= 1'b1;
      // pass is frozen on entry to FIN so it is valid with done
      if (w_state_nx == S_FIN && r_state != S_FIN)
        r_pass <= (r_err_cnt == 8'd0) && !r_tmo && !w_tmo_hit;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_seed    <= seed;
          r_adr     <= ADDR_START;
          r_err_cnt <= '0;
          r_err_adr <= '0;
          r_err_dat <= '0;
          r_tmo     <= 1'b0;
          r_pass    <= 1'b0;
        end
        S_RD: if (wb_ack_i && w_miss) begin
          if (r_err_cnt == 8'd0) begin
            r_err_adr <= r_adr;
            r_err_dat <= wb_dat_i;
          end
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
        S_WGAP: r_adr <= w_at_end ? ADDR_START : r_adr + 16'd2;
        S_RGAP: if (!w_at_end) r_adr <= r_adr + 16'd2;
`ifdef WBM_MTEST_CONT_EN
        S_FIN: if (w_state_nx == S_WR) begin
          r_seed <= r_seed + 16'd1;
          r_adr  <= ADDR_START;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wbm_mtest.sv
// tb_wbm_mtest: table, random and corner-case checks of wbm_mtest
// against a memory slave with read-data corruption and a range-level model.
module tb_wbm_mtest;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        busy, done, pass, tmo;
  logic [7:0]  err_cnt;
  logic [15:0] err_adr, err_dat, adr, dat_o;
  logic [15:0] dat_i = 16'h0000;
  logic        cyc, stb, we;
  logic        ack = 1'b0;
  logic [1:0]  sel;

  logic        start_b = 1'b0;
  logic        busy_b, done_b, pass_b, tmo_b;
  logic [7:0]  err_cnt_b;
  logic [15:0] err_adr_b, err_dat_b, adr_b, dat_o_b;
  logic [15:0] dat_i_b = 16'h0000;
  logic        cyc_b, stb_b, we_b;
  logic        ack_b = 1'b0;
  logic [1:0]  sel_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wbm_mtest #(
    .ADDR_START(16'h0000), .ADDR_END(16'h003E), .TIMEOUT(16)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .tmo(tmo),
    .err_cnt(err_cnt), .err_adr(err_adr), .err_dat(err_dat),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
    .wb_sel_o(sel), .wb_ack_i(ack)
  );

  wbm_mtest #(
    .ADDR_START(16'h0100), .ADDR_END(16'h0100), .TIMEOUT(16)
  ) u_one (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start_b), .seed(seed),
    .busy(busy_b), .done(done_b), .pass(pass_b), .tmo(tmo_b),
    .err_cnt(err_cnt_b), .err_adr(err_adr_b), .err_dat(err_dat_b),
    .wb_adr_o(adr_b), .wb_dat_o(dat_o_b), .wb_dat_i(dat_i_b),
    .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_we_o(we_b),
    .wb_sel_o(sel_b), .wb_ack_i(ack_b)
  );

  // slave A: RAM with random ack latency and per-word read corruption
  logic [15:0] mem [0:32767];
  logic [15:0] flip [0:31];
  bit          no_ack = 1'b0;
  int          lat = 0;
  int          wr_n = 0, rd_n = 0, bad_bus = 0, cyc_hi = 0;
  logic [15:0] w0 = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
      lat <= 0;
    end else begin
      ack <= 1'b0;
      if (cyc && (sel != 2'b11 || adr[0] || !stb)) bad_bus <= bad_bus + 1;
      if (cyc && stb && !ack && !no_ack) begin
        if (lat == 0) begin
          ack <= 1'b1;
          lat <= $urandom_range(0, 2);
          if (we) begin
            mem[adr[15:1]] <= dat_o;
            wr_n <= wr_n + 1;
            if (adr == 16'h0000) w0 <= dat_o;
          end else begin
            dat_i <= mem[adr[15:1]] ^ flip[adr[5:1]];
            rd_n <= rd_n + 1;
          end
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  always @(negedge clk) if (cyc) cyc_hi <= cyc_hi + 1;

  // slave B: single-word RAM, one-cycle ack
  logic [15:0] mem_b = 16'h0000, wd_b = 16'h0000, wa_b = 16'h0000;
  int          wr_b = 0, rd_b = 0;

  always @(posedge clk) begin
    ack_b <= cyc_b && stb_b && !ack_b;
    if (cyc_b && stb_b && !ack_b) begin
      if (we_b) begin
        mem_b <= dat_o_b;
        wd_b  <= dat_o_b;
        wa_b  <= adr_b;
        wr_b  <= wr_b + 1;
      end else begin
        dat_i_b <= mem_b;
        rd_b    <= rd_b + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  int wr0, rd0, cy0;

  task automatic run_a(input logic [15:0] s);
    bit ok;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    wr0 = wr_n;
    rd0 = rd_n;
    cy0 = cyc_hi;
    @(negedge clk);
    start = 1'b0;
    seed  = ~s;
    chk("busy_on", 32'(busy), 32'd1);
    wait_done(ok);
  endtask

  task automatic clear_flips();
    for (int i = 0; i < 32; i++) flip[i] = 16'h0000;
  endtask

  task automatic check_mem(input logic [15:0] s);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (mem[i] !== (16'(i * 2) ^ s)) bad++;
    chk("mem_pattern", 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [4:0]  fidx;
    logic [15:0] fmask;
    logic [7:0]  cnt;
    logic [15:0] eadr;
    logic [15:0] edat;
    logic        epass;
  } vec_t;

  vec_t tv [4];

  initial begin
    bit          ok;
    logic [15:0] s;
    int          ecnt, d;
    logic [15:0] eadr, edat;

    tv[0] = '{16'h0000, 5'd0,  16'h0000, 8'd0, 16'h0000, 16'h0000, 1'b1};
    tv[1] = '{16'h0000, 5'd8,  16'h0001, 8'd1, 16'h0010, 16'h0011, 1'b0};
    tv[2] = '{16'h1234, 5'd31, 16'h8000, 8'd1, 16'h003E, 16'h920A, 1'b0};
    tv[3] = '{16'hFFFF, 5'd0,  16'hFFFF, 8'd1, 16'h0000, 16'h0000, 1'b0};
    clear_flips();

    repeat (3) @(negedge clk);
    chk("rst_status", {busy, done, pass, tmo, err_cnt}, 32'd0);
    chk("rst_err", {err_adr, err_dat}, 32'd0);
    chk("rst_bus", {cyc, stb, we, sel, adr}, 32'd0);
    chk("rst_wdat", 32'(dat_o), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      clear_flips();
      flip[tv[k].fidx] = tv[k].fmask;
      run_a(tv[k].seed);
      chk("tv_cnt", 32'(err_cnt), 32'(tv[k].cnt));
      chk("tv_adr", 32'(err_adr), 32'(tv[k].eadr));
      chk("tv_dat", 32'(err_dat), 32'(tv[k].edat));
      chk("tv_pass", 32'(pass), 32'(tv[k].epass));
      chk("tv_tmo", 32'(tmo), 32'd0);
      chk("tv_xfers", 32'(wr_n - wr0) << 8 | 32'(rd_n - rd0), 32'h2020);
      check_mem(tv[k].seed);
      @(negedge clk);
      chk("tv_after", {done, busy}, 32'd0);
    end

    for (int it = 0; it < 6; it++) begin
      s = 16'($urandom);
      clear_flips();
      for (int i = 0; i < 32; i++)
        if ($urandom_range(0, 5) == 0) flip[i] = 16'($urandom_range(1, 65535));
      ecnt = 0;
      eadr = 16'h0000;
      edat = 16'h0000;
      for (int i = 0; i < 32; i++) begin
        if (flip[i] != 16'h0000) begin
          if (ecnt == 0) begin
            eadr = 16'(i * 2);
            edat = (16'(i * 2) ^ s) ^ flip[i];
          end
          ecnt++;
        end
      end
      run_a(s);
      chk("rnd_cnt", 32'(err_cnt), 32'(ecnt));
      chk("rnd_adr", 32'(err_adr), 32'(eadr));
      chk("rnd_dat", 32'(err_dat), 32'(edat));
      chk("rnd_pass", 32'(pass), 32'(ecnt == 0));
      check_mem(s);
    end
    clear_flips();

    no_ack = 1'b1;
    run_a(16'h0000);
    d = cyc_hi - cy0;
    chk("tmo_flag", 32'(tmo), 32'd1);
    chk("tmo_pass", 32'(pass), 32'd0);
    chk("tmo_window", 32'(d >= 16 && d <= 17), 32'd1);
    chk("tmo_writes", 32'(wr_n - wr0), 32'd0);
    @(negedge clk);
    chk("tmo_idle", {cyc, busy}, 32'd0);
    no_ack = 1'b0;

    @(negedge clk);
    seed  = 16'h55AA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cyc && we && adr != 16'h0000) break;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bus", {cyc, stb, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(16'h55AA);
    chk("arst_cnt", 32'(err_cnt), 32'd0);
    chk("arst_pass", 32'(pass), 32'd1);
    check_mem(16'h55AA);

    @(negedge clk);
    seed    = 16'hA5A5;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_b) begin
        ok = 1'b1;
        break;
      end
    end
    chk("one_done", 32'(ok), 32'd1);
    chk("one_wdat", 32'(wd_b), 32'h0000A4A5);
    chk("one_wadr", 32'(wa_b), 32'h00000100);
    chk("one_xfers", 32'(wr_b) << 8 | 32'(rd_b), 32'h0101);
    chk("one_status", {pass_b, tmo_b, err_cnt_b}, 32'h200);
    chk("one_err", {err_adr_b, err_dat_b}, 32'd0);
    chk("one_bus", {cyc_b, stb_b, we_b, sel_b}, 32'd0);

    @(negedge clk);
    seed  = 16'h0001;
    start = 1'b1;
    wait_done(ok);
    chk("cont_w0_first", 32'(w0), 32'h0001);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(ok);
`ifdef WBM_MTEST_CONT_EN
    chk("cont_w0_second", 32'(w0), 32'h0002);
    check_mem(16'h0002);
`else
    chk("cont_w0_second", 32'(w0), 32'h0001);
    check_mem(16'h0001);
`endif
    chk("cont_pass", 32'(pass), 32'd1);
    @(negedge clk);
    chk("cont_idle", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("cont_stay_idle", 32'(busy), 32'd0);
    chk("bus_protocol", 32'(bad_bus), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
